// File: rtl/sprite_rom_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : sprite_rom_pkg                                                   |
// | Purpose : Shared constants and types for the sprite/number ROM             |
// |           (block_num.mem) and its access arbiter. Holds the ROM geometry,  |
// |           the image sizes, the base addresses of every image in the ROM,   |
// |           and the requester id type.                                       |
// | Ports   : none (package)                                                   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package sprite_rom_pkg;

  localparam int ROM_ADDR_W = 17;
  localparam int ROM_DATA_W = 12;

  // Image geometry in pixels (one ROM word per pixel)
  localparam int BLOCK_W = 10;
  localparam int BLOCK_H = 10;
  localparam int NUM_W   = 5;
  localparam int NUM_H   = 9;

  localparam int BLOCK_WORDS = BLOCK_W * BLOCK_H;
  localparam int DIGIT_WORDS = NUM_W * NUM_H;
  localparam int NUM_BLOCKS  = 7;
  localparam int NUM_DIGITS  = 10;

  // ROM layout: 7 block images, then 10 digit glyphs, then the transparent word
  localparam logic [ROM_ADDR_W-1:0] BLOCK_BASE       = 17'd0;
  localparam logic [ROM_ADDR_W-1:0] DIGIT_BASE       = 17'(NUM_BLOCKS * BLOCK_WORDS);
  localparam logic [ROM_ADDR_W-1:0] TRANSPARENT_ADDR = 17'(NUM_BLOCKS * BLOCK_WORDS
                                                          + NUM_DIGITS * DIGIT_WORDS);

  localparam logic [ROM_DATA_W-1:0] TRANSPARENT = 12'hfff;

  // Requester id, wide enough for up to 8 requesters
  typedef logic [2:0] req_id_t;

  // Base address of block image idx (0..6)
  function automatic logic [ROM_ADDR_W-1:0] block_addr(input int idx);
    return BLOCK_BASE + 17'(idx * BLOCK_WORDS);
  endfunction

  // Base address of digit glyph d (0..9)
  function automatic logic [ROM_ADDR_W-1:0] digit_addr(input int d);
    return DIGIT_BASE + 17'(d * DIGIT_WORDS);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_rom_arbiter_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : rr_pick                                                          |
// | Purpose : Combinational round-robin picker. Finds the first set request    |
// |           at or after ptr, scanning upward and wrapping N-1 -> 0.          |
// | Ports   : req   in  [N-1:0]  request vector                                |
// |           ptr   in  req_id_t start position of the scan                    |
// |           grant out [N-1:0]  one-hot grant, zero when req is zero          |
// |           id    out req_id_t index of the granted bit                      |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module rr_pick
  import sprite_rom_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  req_id_t      ptr,
  output logic [N-1:0] grant,
  output req_id_t      id
);

  logic w_found;
  int   w_idx;

  // Equivalent to rotate-by-ptr / find-first-set / rotate-back, written as a
  // wrapped scan so it works for any N, not just powers of two.
  always_comb begin
    grant   = '0;
    id      = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < N; k++) begin
      w_idx = (int'(ptr) + k) % N;
      if (!w_found && req[w_idx]) begin
        w_found      = 1'b1;
        grant[w_idx] = 1'b1;
        id           = req_id_t'(w_idx);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sprite_rom_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sprite_rom_arbiter                                               |
// | Purpose : Shares the single-port sprite/number ROM between NUM_REQ pixel   |
// |           fetch requesters. Round-robin grant, one ROM read per cycle,     |
// |           fixed ROM_LAT+2 latency response tagged with the requester.      |
// | Config  : ARB_PRIORITY0_EN - when defined, requester 0 has strict priority |
// |           and the others round-robin when requester 0 is idle.             |
// | Ports   : clk, reset         clock / synchronous active-high reset         |
// |           req_valid/addr     per-requester read request                    |
// |           req_ready          one-hot grant                                 |
// |           rsp_valid/data     one-hot response pulse and ROM word           |
// |           rom_en/addr/data   ROM interface                                 |
// |           busy               reads in flight                               |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module sprite_rom_arbiter
  import sprite_rom_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 17,
  parameter int DATA_W  = 12,
  parameter int ROM_LAT = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rom_en,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_data,
  output logic                      busy
);

  // Tag stage k lines up with the ROM pipeline k cycles after rom_en
  localparam int                 c_TAG_DEPTH = ROM_LAT + 1;
  localparam logic [NUM_REQ-1:0] c_ONE_LSB   = {{(NUM_REQ-1){1'b0}}, 1'b1};

  logic [NUM_REQ-1:0] w_pick_req;
  logic [NUM_REQ-1:0] w_pick_grant;
  req_id_t            w_pick_id;
  logic [NUM_REQ-1:0] w_grant;
  req_id_t            w_gid;
  logic               w_upd_ptr;
  logic               w_hs;
  req_id_t            w_next_ptr;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [NUM_REQ-1:0] w_tail_onehot;

  req_id_t            r_rr_ptr;
  logic               r_rom_en;
  logic [ADDR_W-1:0]  r_rom_addr;
  logic [c_TAG_DEPTH-1:0] r_tag_v;
  req_id_t            r_tag_id [c_TAG_DEPTH];
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [DATA_W-1:0]  r_rsp_data;

`ifdef ARB_PRIORITY0_EN
  // Requester 0 is served by the priority override, so keep it out of the ring
  assign w_pick_req = {req_valid[NUM_REQ-1:1], 1'b0};
`else
  assign w_pick_req = req_valid;
`endif

  rr_pick #(
    .N (NUM_REQ)
  ) u_rr_pick (
    .req   (w_pick_req),
    .ptr   (r_rr_ptr),
    .grant (w_pick_grant),
    .id    (w_pick_id)
  );

  always_comb begin
    w_grant   = w_pick_grant;
    w_gid     = w_pick_id;
    w_upd_ptr = |w_pick_grant;
`ifdef ARB_PRIORITY0_EN
    if (req_valid[0]) begin
      w_grant   = c_ONE_LSB;
      w_gid     = '0;
      w_upd_ptr = 1'b0;
    end
`endif
    if (reset) begin
      w_grant   = '0;
      w_upd_ptr = 1'b0;
    end
  end

  // The grant is always a subset of req_valid, so any grant bit is a handshake
  assign w_hs       = |w_grant;
  assign w_next_ptr = (int'(w_gid) == NUM_REQ - 1) ? '0 : w_gid + 3'd1;

  always_comb begin
    w_sel_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) w_sel_addr = req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  assign w_tail_onehot = c_ONE_LSB << r_tag_id[c_TAG_DEPTH-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr    <= '0;
      r_rom_en    <= 1'b0;
      r_rom_addr  <= '0;
      r_tag_v     <= '0;
      for (int k = 0; k < c_TAG_DEPTH; k++) r_tag_id[k] <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
    end else begin
      if (w_upd_ptr) r_rr_ptr <= w_next_ptr;

      r_rom_en <= w_hs;
      if (w_hs) r_rom_addr <= w_sel_addr;

      r_tag_v[0]  <= w_hs;
      r_tag_id[0] <= w_gid;
      for (int k = 1; k < c_TAG_DEPTH; k++) begin
        r_tag_v[k]  <= r_tag_v[k-1];
        r_tag_id[k] <= r_tag_id[k-1];
      end

      // Last tag stage coincides with valid rom_data; data is zeroed when idle
      r_rsp_valid <= r_tag_v[c_TAG_DEPTH-1] ? w_tail_onehot : '0;
      r_rsp_data  <= r_tag_v[c_TAG_DEPTH-1] ? rom_data : '0;
    end
  end

  assign req_ready = w_grant;
  assign rom_en    = r_rom_en;
  assign rom_addr  = r_rom_addr;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign busy      = (|r_tag_v) | (|r_rsp_valid);

endmodule
`default_nettype wire

// File: tb/tb_sprite_rom_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_sprite_rom_arbiter                                            |
// | Purpose : Self-checking bench for sprite_rom_arbiter (NUM_REQ=4,           |
// |           ROM_LAT=1) with a one-cycle model ROM returning addr[11:0].      |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_sprite_rom_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [67:0] req_addr;
  logic [3:0]  req_ready;
  logic [3:0]  rsp_valid;
  logic [11:0] rsp_data;
  logic        rom_en;
  logic [16:0] rom_addr;
  logic [11:0] rom_data;
  logic        busy;

  int n_checks;
  int n_fail;

  sprite_rom_arbiter #(
    .NUM_REQ (4),
    .ADDR_W  (17),
    .DATA_W  (12),
    .ROM_LAT (1)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rom_en    (rom_en),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model ROM: one-cycle read, word = low 12 address bits
  initial rom_data = '0;
  always @(posedge clk) if (rom_en) rom_data <= rom_addr[11:0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  logic [3:0]  exp_g [8];
  logic [11:0] exp_d [4];
  logic [3:0]  slot_oh [8];
  logic [11:0] slot_d [8];
  logic [3:0]  last_hs;
  int          cnt1, cnt2;

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    last_hs   = '0;
    for (int i = 0; i < 8; i++) begin slot_oh[i] = '0; slot_d[i] = '0; end

    // ---------------- reset values ----------------
    tick(); tick();
    req_valid = 4'b1111;
    settle();
    chk("rst_ready", req_ready, 4'b0000);
    chk("rst_rom_en", rom_en, 1'b0);
    chk("rst_rom_addr", rom_addr, 17'd0);
    chk("rst_rsp_valid", rsp_valid, 4'b0000);
    chk("rst_rsp_data", rsp_data, 12'd0);
    chk("rst_busy", busy, 1'b0);
    req_valid = '0;
    reset = 1'b0;
    tick();

    // ---------------- single read, latency ----------------
    req_addr[16:0] = 17'd700;
    req_valid = 4'b0001;
    settle();
    chk("t1_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    settle();
    chk("t1_rom_en", rom_en, 1'b1);
    chk("t1_rom_addr", rom_addr, 17'd700);
    chk("t1_busy", busy, 1'b1);
    tick();
    chk("t1_rsp_early", rsp_valid, 4'b0000);
    tick();
    chk("t1_rsp_valid", rsp_valid, 4'b0001);
    chk("t1_rsp_data", rsp_data, 12'h2bc);
    tick();
    chk("t1_rsp_clr", rsp_valid, 4'b0000);
    chk("t1_data_clr", rsp_data, 12'h000);
    chk("t1_busy_clr", busy, 1'b0);

    // ---------------- all four valid, 8 cycles ----------------
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req_addr = {17'h1abcd, 17'd300, 17'd4097, 17'd10};
    exp_d[0] = 12'h00a; exp_d[1] = 12'h001; exp_d[2] = 12'h12c; exp_d[3] = 12'hbcd;
    for (int c = 0; c < 11; c++) begin
      req_valid = (c < 8) ? 4'b1111 : 4'b0000;
      settle();
      if (c < 8) chk("t2_grant", req_ready, 4'b0001 << (c % 4));
      if (c >= 3) begin
        chk("t2_rsp_valid", rsp_valid, 4'b0001 << ((c - 3) % 4));
        chk("t2_rsp_data", rsp_data, exp_d[(c - 3) % 4]);
      end
      tick();
    end

    // ---------------- wrap and priority option ----------------
`ifdef ARB_PRIORITY0_EN
    exp_g[0] = 4'b0100; exp_g[1] = 4'b0001; exp_g[2] = 4'b0001;
    exp_g[3] = 4'b0001; exp_g[4] = 4'b0001; exp_g[5] = 4'b0001;
`else
    exp_g[0] = 4'b0100; exp_g[1] = 4'b0001; exp_g[2] = 4'b0100;
    exp_g[3] = 4'b0001; exp_g[4] = 4'b0010; exp_g[5] = 4'b0100;
`endif
    for (int c = 0; c < 6; c++) begin
      req_valid = (c == 0) ? 4'b0100 : (c < 3) ? 4'b0101 : 4'b0111;
      settle();
      chk("t3_grant", req_ready, exp_g[c]);
      tick();
    end
    req_valid = '0;
    for (int c = 0; c < 4; c++) tick();
    chk("t3_busy_idle", busy, 1'b0);

    // ---------------- requester drops valid before grant ----------------
    req_valid = 4'b0110;
    settle();
    chk("t3_drop_grant", req_ready, 4'b0010);
    tick();
    req_valid = 4'b0000;
    settle();
    chk("t3_drop_none", req_ready, 4'b0000);
    cnt1 = 0; cnt2 = 0;
    for (int c = 0; c < 5; c++) begin
      if (rsp_valid[1]) cnt1++;
      if (rsp_valid[2]) cnt2++;
      tick();
    end
    chk("t3_drop_rsp1", cnt1, 1);
    chk("t3_drop_rsp2", cnt2, 0);

    // ---------------- reset mid-burst ----------------
`ifdef ARB_PRIORITY0_EN
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0001; exp_g[2] = 4'b0001;
`else
    exp_g[0] = 4'b0100; exp_g[1] = 4'b0001; exp_g[2] = 4'b0010;
`endif
    for (int c = 0; c < 3; c++) begin
      req_valid = 4'b0111;
      settle();
      chk("t4_burst", req_ready, exp_g[c]);
      tick();
    end
    reset = 1'b1;
    settle();
    chk("t4_ready_in_rst", req_ready, 4'b0000);
    tick();
    reset = 1'b0;
    req_valid = '0;
    settle();
    chk("t4_rom_en", rom_en, 1'b0);
    chk("t4_rom_addr", rom_addr, 17'd0);
    chk("t4_busy", busy, 1'b0);
    chk("t4_rsp_data", rsp_data, 12'd0);
    for (int c = 0; c < 4; c++) begin
      chk("t4_no_rsp", rsp_valid, 4'b0000);
      tick();
    end
    req_valid = 4'b1111;
    settle();
    chk("t4_first_grant", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    for (int c = 0; c < 4; c++) tick();

    // ---------------- random traffic with scoreboard ----------------
    for (int cyc = 0; cyc < 404; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if (last_hs[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && cyc < 400 && $urandom_range(0, 2) == 0) begin
          req_valid[i] = 1'b1;
          req_addr[i*17 +: 17] = 17'($urandom);
        end
      end
      settle();
      chk("rnd_rsp_valid", rsp_valid, slot_oh[cyc % 8]);
      chk("rnd_rsp_data", rsp_data, slot_d[cyc % 8]);
      slot_oh[cyc % 8] = '0;
      slot_d[cyc % 8]  = '0;
      chk("rnd_onehot", $onehot0(req_ready), 1'b1);
      chk("rnd_subset", req_ready & ~req_valid, 4'b0000);
      last_hs = req_ready & req_valid;
      for (int i = 0; i < 4; i++) begin
        if (last_hs[i]) begin
          slot_oh[(cyc + 3) % 8] = 4'b0001 << i;
          slot_d[(cyc + 3) % 8]  = req_addr[i*17 +: 12];
        end
      end
      tick();
    end
    chk("rnd_busy_end", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
